// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC/sequencing unit: branch funct3 codes, FSM states
// and default vector addresses.
package pc_fetch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } fetch_state_e;

  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h100;

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a conditional-branch condition from funct3 and the ALU compare flags.
// Reserved encodings (010, 011) never take.
module branch_cond_eval
  import pc_fetch_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (br_op)
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_BLT:  cond = lt;
      BR_BGE:  cond = ~lt;
      BR_BLTU: cond = ltu;
      BR_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, redirect selection, misaligned-target trap FSM and retire counter
// for the single-cycle core.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              IALIGN_LOG2  = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       br_op,
  input  logic             jump,
  input  logic             jalr,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic             trap_ack,
  output logic [XLEN-1:0]  pc_current,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             branch_taken,
  output logic             trap_valid,
  output logic [XLEN-1:0]  trap_epc,
  output logic [XLEN-1:0]  trap_badaddr,
  output logic [CNT_W-1:0] retire_cnt
);

  fetch_state_e    state, state_nxt;
  logic            cond, misaligned;
  logic            do_trap, do_retire, do_ack;
  logic [XLEN-1:0] pc_imm, jalr_tgt, target, next_pc;

  branch_cond_eval u_cond (
    .br_op (br_op),
    .zero  (zero),
    .lt    (lt),
    .ltu   (ltu),
    .cond  (cond)
  );

  assign pc_plus4     = pc_current + XLEN'(4);
  assign pc_imm       = pc_current + imm;
  assign jalr_tgt     = (rs1 + imm) & ~XLEN'(1);
  assign branch_taken = jalr | jump | (branch & cond);
  assign target       = jalr ? jalr_tgt : pc_imm;
  assign next_pc      = branch_taken ? target : pc_plus4;
  // Only a taken redirect can fault; the sequential path stays aligned.
  assign misaligned   = branch_taken & (|target[IALIGN_LOG2-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (!stall && misaligned) state_nxt = ST_TRAP;
      ST_TRAP: if (trap_ack)             state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    do_trap   = 1'b0;
    do_retire = 1'b0;
    do_ack    = 1'b0;
    case (state)
      ST_RUN: begin
        do_trap   = !stall && misaligned;
        do_retire = !stall && !misaligned;
      end
      ST_TRAP: do_ack = trap_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_current   <= RESET_VECTOR;
      trap_valid   <= 1'b0;
      trap_epc     <= '0;
      trap_badaddr <= '0;
      retire_cnt   <= '0;
    end else begin
      if (do_trap) begin
        pc_current   <= TRAP_VECTOR;
        trap_epc     <= pc_current;
        trap_badaddr <= target;
        trap_valid   <= 1'b1;
      end else if (do_retire) begin
        pc_current   <= next_pc;
        retire_cnt   <= retire_cnt + CNT_W'(1);
      end
      if (do_ack) trap_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized check of pc_fetch_unit against a behavioural model;
// a second instance with a 4-bit retire counter checks counter wrap.
module tb_pc_fetch_unit;

  localparam logic [63:0] TRAP_V  = 64'h100;
  localparam logic [63:0] RESET_V = 64'h0;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jalr, zero, lt, ltu, trap_ack;
  logic [2:0]  br_op;
  logic [63:0] imm, rs1;

  logic [63:0] pc_current, pc_plus4, trap_epc, trap_badaddr;
  logic        branch_taken, trap_valid;
  logic [31:0] retire_cnt;

  logic [63:0] pc_current_n, pc_plus4_n, trap_epc_n, trap_badaddr_n;
  logic        branch_taken_n, trap_valid_n;
  logic [3:0]  retire_cnt_n;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .br_op(br_op),
    .jump(jump), .jalr(jalr), .zero(zero), .lt(lt), .ltu(ltu), .imm(imm),
    .rs1(rs1), .trap_ack(trap_ack), .pc_current(pc_current), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .trap_valid(trap_valid), .trap_epc(trap_epc),
    .trap_badaddr(trap_badaddr), .retire_cnt(retire_cnt)
  );

  pc_fetch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .br_op(br_op),
    .jump(jump), .jalr(jalr), .zero(zero), .lt(lt), .ltu(ltu), .imm(imm),
    .rs1(rs1), .trap_ack(trap_ack), .pc_current(pc_current_n), .pc_plus4(pc_plus4_n),
    .branch_taken(branch_taken_n), .trap_valid(trap_valid_n), .trap_epc(trap_epc_n),
    .trap_badaddr(trap_badaddr_n), .retire_cnt(retire_cnt_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [63:0] m_pc, m_epc, m_bad;
  logic [31:0] m_cnt;
  bit          m_trap, m_tv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_V; m_epc = '0; m_bad = '0; m_cnt = '0; m_trap = 0; m_tv = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":pc"},      pc_current,          m_pc);
    chk({tag, ":pc4"},     pc_plus4,            m_pc + 64'd4);
    chk({tag, ":tvalid"},  {63'd0, trap_valid}, {63'd0, m_tv});
    chk({tag, ":epc"},     trap_epc,            m_epc);
    chk({tag, ":badaddr"}, trap_badaddr,        m_bad);
    chk({tag, ":cnt"},     {32'd0, retire_cnt}, {32'd0, m_cnt});
    chk({tag, ":cnt4"},    {60'd0, retire_cnt_n}, {60'd0, m_cnt[3:0]});
    chk({tag, ":pc_n"},    pc_current_n,        m_pc);
  endtask

  function automatic bit m_cond();
    case (br_op)
      3'd0: return zero;
      3'd1: return !zero;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 0;
    endcase
  endfunction

  // One clock: check the same-cycle redirect, advance model, check registers.
  task automatic step(input string tag);
    bit          taken;
    logic [63:0] tgt;
    #1;
    taken = jalr || jump || (branch && m_cond());
    tgt   = jalr ? ((rs1 + imm) & ~64'd1) : (m_pc + imm);
    chk({tag, ":taken"}, {63'd0, branch_taken}, {63'd0, taken});
    if (m_trap) begin
      if (trap_ack) begin m_trap = 0; m_tv = 0; end
    end else if (!stall) begin
      if (taken && (tgt % 4 != 0)) begin
        m_trap = 1; m_tv = 1; m_epc = m_pc; m_bad = tgt; m_pc = TRAP_V;
      end else begin
        m_pc  = taken ? tgt : m_pc + 64'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic clr();
    stall = 0; branch = 0; br_op = 3'd0; jump = 0; jalr = 0;
    zero = 0; lt = 0; ltu = 0; imm = '0; rs1 = '0; trap_ack = 0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_regs(tag);
    clr();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int off;
    clr();
    reset = 1'b1;
    model_reset();
    #1;
    check_regs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 4; i++) step("seq");

    // Conditional branches at pc=16
    branch = 1; br_op = 3'b000; zero = 1; imm = 64'd16; step("beq");
    br_op = 3'b001; step("bne_nt");
    clr(); branch = 1; br_op = 3'b100; lt = 1; imm = longint'(-20); step("blt_back");
    clr(); branch = 1; br_op = 3'b110; ltu = 1; imm = 64'd8; step("bltu");
    br_op = 3'b111; step("bgeu_nt");
    br_op = 3'b010; zero = 1; lt = 1; ltu = 1; step("rsvd_010");
    br_op = 3'b011; step("rsvd_011");
    clr(); step("seq2");

    // Stall beats a pending jump at pc=40
    jump = 1; imm = 64'd8; stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    stall = 0; step("stall_rel");

    // jalr clears bit 0, then a misaligned jump traps
    clr(); jalr = 1; rs1 = 64'h101; step("jalr");
    clr(); jump = 1; imm = 64'd6; step("trap_enter");
    clr(); jump = 1; stall = 1; imm = 64'd6;
    for (int i = 0; i < 5; i++) step("trap_hold");
    clr(); trap_ack = 1; step("trap_ack");
    clr(); step("post_trap");
    trap_ack = 1; step("ack_in_run");

    // Reset while trapped, then while stalled
    clr(); jump = 1; imm = 64'd2; step("trap2");
    async_reset("rst_trap");
    clr(); stall = 1; step("stall_pre_rst");
    async_reset("rst_stall");

    // 17 retirements: 4-bit counter wraps to 1
    clr();
    for (int i = 0; i < 17; i++) step("wrap");
    chk("wrap_cnt4", {60'd0, retire_cnt_n}, 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      clr();
      off = int'($urandom_range(0, 15)) - 8;
      imm = longint'(off) * 4;
      if ($urandom_range(0, 7) == 0) imm = imm + 64'($urandom_range(1, 3));
      zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
      br_op = 3'($urandom);
      case ($urandom_range(0, 9))
        4, 5, 6: branch = 1;
        7:       jump = 1;
        8: begin
          jalr = 1;
          rs1 = {$urandom, $urandom} & ~64'd3;
          if ($urandom_range(0, 3) == 0) rs1 = rs1 | 64'd2 | 64'($urandom_range(0, 1));
        end
        default: ;
      endcase
      stall    = ($urandom_range(0, 4) == 0);
      trap_ack = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
